// File: rtl/seq_divider16_if.sv
// rtl/seq_divider16_if.sv - handshake and result bundle between the ALU controller and the divider
interface seq_divider16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             signedMode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             divByZero;
    logic             overflow;

    modport master (
        output start, dividend, divisor, signedMode,
        input  busy, done, quotient, remainder, divByZero, overflow
    );

    modport slave (
        input  start, dividend, divisor, signedMode,
        output busy, done, quotient, remainder, divByZero, overflow
    );
endinterface

// File: rtl/seq_divider16.sv
// rtl/seq_divider16.sv - sequential restoring divider, one quotient bit per clock (optional SIGNED_DIV_EN)
module seq_divider16 #(
    parameter int WIDTH = 16
) (
    input logic          clk,
    input logic          reset,
    seq_divider16_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] rem_acc, quo_acc, div_reg;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo_out, rem_out;
    logic             dbz_out, ovf_out;

    logic busy_c, done_c, load, load_zero, finish;

    logic [WIDTH-1:0] r_shift, r_next, q_next;
    logic [WIDTH:0]   diff;

    logic [WIDTH-1:0] dvd_load, dsr_load, q_final, r_final;
    logic             ovf_final;

    // State register; reset overrides any start in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake outputs; start is only looked at in IDLE
    always_comb begin
        next_state = state;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        load       = 1'b0;
        load_zero  = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        load_zero  = 1'b1;
                        next_state = DONE;
                    end else begin
                        load       = 1'b1;
                        next_state = RUN;
                    end
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (count == '0) begin
                    finish     = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                done_c     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor
    always_comb begin
        r_shift = {rem_acc[WIDTH-2:0], quo_acc[WIDTH-1]};
        diff    = {1'b0, r_shift} - {1'b0, div_reg};
        if (!diff[WIDTH]) begin
            r_next = diff[WIDTH-1:0];
            q_next = {quo_acc[WIDTH-2:0], 1'b1};
        end else begin
            r_next = r_shift;
            q_next = {quo_acc[WIDTH-2:0], 1'b0};
        end
    end

`ifdef SIGNED_DIV_EN
    logic neg_q, neg_r, ovf_pend;
    logic sgn_dvd, sgn_dsr;

    // Divide magnitudes; restore signs on the final step
    always_comb begin
        sgn_dvd   = bus.signedMode & bus.dividend[WIDTH-1];
        sgn_dsr   = bus.signedMode & bus.divisor[WIDTH-1];
        dvd_load  = sgn_dvd ? -bus.dividend : bus.dividend;
        dsr_load  = sgn_dsr ? -bus.divisor : bus.divisor;
        q_final   = neg_q ? -q_next : q_next;
        r_final   = neg_r ? -r_next : r_next;
        ovf_final = ovf_pend;
    end

    // Sign bookkeeping captured with the operands; most-negative / -1 is flagged up front
    always_ff @(posedge clk) begin
        if (reset) begin
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ovf_pend <= 1'b0;
        end else if (load) begin
            neg_q    <= sgn_dvd ^ sgn_dsr;
            neg_r    <= sgn_dvd;
            ovf_pend <= bus.signedMode
                        && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                        && (bus.divisor == '1);
        end
    end
`else
    logic sign_unused;
    assign sign_unused = bus.signedMode;

    // Unsigned only: operands and results pass straight through
    always_comb begin
        dvd_load  = bus.dividend;
        dsr_load  = bus.divisor;
        q_final   = q_next;
        r_final   = r_next;
        ovf_final = 1'b0;
    end
`endif

    // Operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_acc <= '0;
            quo_acc <= '0;
            div_reg <= '0;
            count   <= '0;
            quo_out <= '0;
            rem_out <= '0;
            dbz_out <= 1'b0;
            ovf_out <= 1'b0;
        end else if (load_zero) begin
            quo_out <= '1;
            rem_out <= bus.dividend;
            dbz_out <= 1'b1;
            ovf_out <= 1'b0;
        end else if (load) begin
            rem_acc <= '0;
            quo_acc <= dvd_load;
            div_reg <= dsr_load;
            count   <= CW'(WIDTH - 1);
        end else if (state == RUN) begin
            rem_acc <= r_next;
            quo_acc <= q_next;
            count   <= count - 1'b1;
            if (finish) begin
                quo_out <= q_final;
                rem_out <= r_final;
                dbz_out <= 1'b0;
                ovf_out <= ovf_final;
            end
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.quotient  = quo_out;
    assign bus.remainder = rem_out;
    assign bus.divByZero = dbz_out;
    assign bus.overflow  = ovf_out;
endmodule

// File: tb/tb_seq_divider16.sv
// tb/tb_seq_divider16.sv - self-checking bench for seq_divider16
module tb_seq_divider16;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seq_divider16_if #(.WIDTH(W)) bus ();
    seq_divider16 #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } res_t;

    int tests = 0;
    int fails = 0;

    // Arithmetic reference for one division
    function automatic res_t calc(logic [W-1:0] a, logic [W-1:0] b, logic sm);
        res_t x;
        int sa, sb;
        x.q = '0; x.r = '0; x.dz = 1'b0; x.ov = 1'b0;
        sa = 0; sb = 0;
        if (b == 0) begin
            x.q = '1; x.r = a; x.dz = 1'b1;
        end
`ifdef SIGNED_DIV_EN
        else if (sm) begin
            if (a == 16'h8000 && b == 16'hFFFF) begin
                x.q = 16'h8000; x.r = '0; x.ov = 1'b1;
            end else begin
                sa = int'($signed(a));
                sb = int'($signed(b));
                x.q = W'(sa / sb);
                x.r = W'(sa % sb);
            end
        end
`endif
        else begin
            x.q = a / b;
            x.r = a % b;
        end
        return x;
    endfunction

    // Transaction-level model advanced on each clock edge
    int   cyc = 0;
    logic m_active = 1'b0;
    int   m_done = 0;
    res_t m_res = '0;
    res_t held = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_active <= 1'b0;
            held     <= '0;
        end else if (m_active && (cyc + 1 == m_done)) begin
            held <= m_res;
        end else if (m_active && (cyc + 1 == m_done + 1)) begin
            m_active <= 1'b0;
        end else if (!m_active && bus.start) begin
            m_active <= 1'b1;
            m_res    <= calc(bus.dividend, bus.divisor, bus.signedMode);
            if (bus.divisor == 0) begin
                m_done <= cyc + 1;
                held   <= calc(bus.dividend, bus.divisor, bus.signedMode);
            end else begin
                m_done <= cyc + 1 + W;
            end
        end
    end

    task automatic check_cycle();
        logic eb, ed;
        eb = m_active && (cyc < m_done);
        ed = m_active && (cyc == m_done);
        tests++;
        if (bus.busy !== eb || bus.done !== ed || bus.quotient !== held.q ||
            bus.remainder !== held.r || bus.divByZero !== held.dz || bus.overflow !== held.ov) begin
            fails++;
            $display("FAIL cycle_check @%0d: got busy=%b done=%b q=%h r=%h dz=%b ov=%b, want busy=%b done=%b q=%h r=%h dz=%b ov=%b",
                     cyc, bus.busy, bus.done, bus.quotient, bus.remainder, bus.divByZero, bus.overflow,
                     eb, ed, held.q, held.r, held.dz, held.ov);
        end
    endtask

    task automatic step(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_cycle();
            #1;
        end
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, got, exp);
        end
    endtask

    task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic sm);
        bus.start      = 1'b1;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.signedMode = sm;
        step(1);
        bus.start      = 1'b0;
        bus.dividend   = W'($urandom);
        bus.divisor    = W'($urandom);
        bus.signedMode = 1'($urandom);
    endtask

    task automatic wait_done(string name, output logic found);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.done === 1'b1) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: got no done, want done within 60 cycles", name);
        end
    endtask

    task automatic run_check(string name, logic [W-1:0] a, logic [W-1:0] b, logic sm,
                             logic [W-1:0] eq, logic [W-1:0] er, logic edz, logic eov, int elat);
        int   e0;
        logic found;
        e0 = cyc + 1;
        issue(a, b, sm);
        wait_done(name, found);
        if (found) begin
            chk({name, " quotient"}, 32'(bus.quotient), 32'(eq));
            chk({name, " remainder"}, 32'(bus.remainder), 32'(er));
            chk({name, " divByZero"}, 32'(bus.divByZero), 32'(edz));
            chk({name, " overflow"}, 32'(bus.overflow), 32'(eov));
            chk({name, " latency"}, 32'(cyc - e0 + 1), 32'(elat));
        end
        step(1);
    endtask

    initial begin
        int   e0;
        logic found;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        bus.signedMode = 1'b0;
        step(2);
        reset = 1'b0;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset quotient", 32'(bus.quotient), 32'd0);
        chk("reset remainder", 32'(bus.remainder), 32'd0);
        step(2);

        run_check("basic", 16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 1'b0, 17);
        run_check("full_scale", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17);
        run_check("small_num", 16'h0005, 16'h0009, 1'b0, 16'h0000, 16'h0005, 1'b0, 1'b0, 17);
        run_check("div_zero", 16'd1234, 16'd0, 1'b0, 16'hFFFF, 16'd1234, 1'b1, 1'b0, 1);
        run_check("after_zero", 16'd10, 16'd3, 1'b0, 16'd3, 16'd1, 1'b0, 1'b0, 17);

        e0 = cyc + 1;
        issue(16'd200, 16'd10, 1'b0);
        step(3);
        issue(16'd9, 16'd3, 1'b0);
        wait_done("busy_ignore", found);
        if (found) begin
            chk("busy_ignore quotient", 32'(bus.quotient), 32'd20);
            chk("busy_ignore remainder", 32'(bus.remainder), 32'd0);
            chk("busy_ignore latency", 32'(cyc - e0 + 1), 32'd17);
        end
        issue(16'd7, 16'd2, 1'b0);
        chk("start_in_done busy", 32'(bus.busy), 32'd0);
        chk("start_in_done quotient", 32'(bus.quotient), 32'd20);
        run_check("after_done", 16'd50, 16'd6, 1'b0, 16'd8, 16'd2, 1'b0, 1'b0, 17);

        issue(16'd5000, 16'd7, 1'b0);
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid_reset busy", 32'(bus.busy), 32'd0);
        chk("mid_reset quotient", 32'(bus.quotient), 32'd0);
        chk("mid_reset remainder", 32'(bus.remainder), 32'd0);
        step(20);
        run_check("after_reset", 16'd21, 16'd4, 1'b0, 16'd5, 16'd1, 1'b0, 1'b0, 17);

`ifdef SIGNED_DIV_EN
        run_check("neg_dividend", 16'hFF9C, 16'd7, 1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 17);
        run_check("neg_divisor", 16'd100, 16'hFFF9, 1'b1, 16'hFFF2, 16'd2, 1'b0, 1'b0, 17);
        run_check("signed_ovf", 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1, 17);
        run_check("signed_zero", 16'hFF9C, 16'd0, 1'b1, 16'hFFFF, 16'hFF9C, 1'b1, 1'b0, 1);
        run_check("mode0_unsigned", 16'hFF9C, 16'd7, 1'b0, 16'h2484, 16'h0000, 1'b0, 1'b0, 17);
`else
        run_check("neg_dividend", 16'hFF9C, 16'd7, 1'b1, 16'h2484, 16'h0000, 1'b0, 1'b0, 17);
        run_check("neg_divisor", 16'd100, 16'hFFF9, 1'b1, 16'h0000, 16'd100, 1'b0, 1'b0, 17);
        run_check("signed_ovf", 16'h8000, 16'hFFFF, 1'b1, 16'h0000, 16'h8000, 1'b0, 1'b0, 17);
`endif
        step(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
